// File: rtl/bpred_update_ctrl.sv
// Branch predictor update controller: queues resolved-branch updates and arbitrates the
// single table port between fetch lookups, read-modify-write updates and whole-table clears.
module bpred_update_ctrl #(
    parameter int QDEPTH = 4,
    parameter int IDX_W  = 6
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             update_predictor,
    input  logic [31:0]      pc_to_update,
    input  logic [31:0]      update_addr,
    input  logic             branch_result,
    input  logic             prediction,
    input  logic             is_jalr,
    input  logic             lookup_req,
    input  logic [31:0]      lookup_pc,
    input  logic             clear_req,
    input  logic [33:0]      tbl_rdata,
    output logic             upd_ready,
    output logic             lookup_grant,
    output logic             tbl_en,
    output logic             tbl_we,
    output logic [IDX_W-1:0] tbl_idx,
    output logic [33:0]      tbl_wdata,
    output logic             busy_clear,
    output logic [15:0]      mispredict_cnt
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] CLR_LAST = '1;

    typedef enum logic [1:0] {CLEAR, IDLE, UPD_RD, UPD_WR} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] clr_idx_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      mcnt_q, mcnt_d;

    // Only the table index and the word-aligned target of each update are kept.
    logic [IDX_W-1:0]  idx_mem_q [QDEPTH];
    logic [29:0]       tgt_mem_q [QDEPTH];
    logic [QDEPTH-1:0] taken_mem_q;

    logic             full, empty, push, pop, lookup_ok;
    logic [IDX_W-1:0] head_idx;
    logic [29:0]      head_tgt;
    logic             head_taken;
    logic [33:0]      upd_wdata;
    logic             unused_bits;

    function automatic logic [1:0] sat_ctr(input logic [1:0] c, input logic taken);
        if (taken)
            return (c == 2'b11) ? c : c + 2'b01;
        else
            return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    // Target field holds the word address of the branch target.
    function automatic logic [33:0] next_entry(input logic [33:0] old, input logic taken,
                                               input logic [29:0] tgt_word);
        logic [31:0] tgt;
        tgt = taken ? {2'b00, tgt_word} : old[33:2];
        return {tgt, sat_ctr(old[1:0], taken)};
    endfunction

    assign full       = (count_q == CNT_W'(QDEPTH));
    assign empty      = (count_q == '0);
    assign lookup_ok  = lookup_req && !full;
    assign upd_ready  = nRST && !full && (state_q != CLEAR);
    assign push       = update_predictor && upd_ready && !is_jalr;
    assign pop        = (state_q == UPD_WR);
    assign busy_clear = (state_q == CLEAR);
    assign mispredict_cnt = mcnt_q;

    assign head_idx   = idx_mem_q[rd_ptr_q];
    assign head_tgt   = tgt_mem_q[rd_ptr_q];
    assign head_taken = taken_mem_q[rd_ptr_q];
    assign upd_wdata  = next_entry(tbl_rdata, head_taken, head_tgt);

    assign unused_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0],
                           pc_to_update[31:IDX_W+2], pc_to_update[1:0], update_addr[1:0]};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mcnt_d   = mcnt_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (push && (prediction != branch_result) && (mcnt_q != 16'hFFFF))
            mcnt_d = mcnt_q + 16'd1;
    end

    always_comb begin
        lookup_grant = 1'b0;
        tbl_en       = 1'b0;
        tbl_we       = 1'b0;
        tbl_idx      = '0;
        tbl_wdata    = '0;
        case (state_q)
            CLEAR: begin
                tbl_en  = 1'b1;
                tbl_we  = 1'b1;
                tbl_idx = clr_idx_q;
            end
            IDLE: begin
                if (lookup_ok) begin
                    lookup_grant = 1'b1;
                    tbl_en       = 1'b1;
                    tbl_idx      = lookup_pc[IDX_W+1:2];
                end
            end
            UPD_RD: begin
                tbl_en  = 1'b1;
                tbl_idx = head_idx;
            end
            UPD_WR: begin
                tbl_idx = head_idx;
                // A clear arriving now abandons the pending write.
                if (!clear_req) begin
                    tbl_en    = 1'b1;
                    tbl_we    = 1'b1;
                    tbl_wdata = upd_wdata;
                end
            end
            default: ;
        endcase
        // No table access at all while reset is held.
        if (!nRST) begin
            lookup_grant = 1'b0;
            tbl_en       = 1'b0;
            tbl_we       = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST || clear_req) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            mcnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mcnt_q   <= mcnt_d;
            case (state_q)
                CLEAR: begin
                    clr_idx_q <= clr_idx_q + IDX_W'(1);
                    if (clr_idx_q == CLR_LAST) state_q <= IDLE;
                end
                IDLE:    if (!empty && !lookup_ok) state_q <= UPD_RD;
                UPD_RD:  state_q <= UPD_WR;
                UPD_WR:  state_q <= IDLE;
                default: state_q <= CLEAR;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            idx_mem_q[wr_ptr_q]   <= pc_to_update[IDX_W+1:2];
            tgt_mem_q[wr_ptr_q]   <= update_addr[31:2];
            taken_mem_q[wr_ptr_q] <= branch_result;
        end
    end

endmodule

// File: tb/tb_bpred_update_ctrl.sv
// Bench for bpred_update_ctrl: a behavioural table/queue model checked every cycle,
// directed sequences with literal expectations, then randomized traffic.
module tb_bpred_update_ctrl;
    localparam int QD = 4;
    localparam int IW = 6;
    localparam int P_CLR = 0, P_IDLE = 1, P_RD = 2, P_WR = 3;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        nRST, update_predictor, branch_result, prediction, is_jalr;
    logic        lookup_req, clear_req;
    logic [31:0] pc_to_update, update_addr, lookup_pc;
    logic [33:0] tbl_rdata;
    logic        upd_ready, lookup_grant, tbl_en, tbl_we, busy_clear;
    logic [IW-1:0] tbl_idx;
    logic [33:0] tbl_wdata;
    logic [15:0] mispredict_cnt;

    bpred_update_ctrl #(.QDEPTH(QD), .IDX_W(IW)) dut (
        .CLK(CLK), .nRST(nRST), .update_predictor(update_predictor),
        .pc_to_update(pc_to_update), .update_addr(update_addr),
        .branch_result(branch_result), .prediction(prediction), .is_jalr(is_jalr),
        .lookup_req(lookup_req), .lookup_pc(lookup_pc), .clear_req(clear_req),
        .tbl_rdata(tbl_rdata), .upd_ready(upd_ready), .lookup_grant(lookup_grant),
        .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_wdata(tbl_wdata),
        .busy_clear(busy_clear), .mispredict_cnt(mispredict_cnt)
    );

    // Table RAM seen by the DUT, pre-filled with garbage so an incomplete clear shows up.
    logic [33:0] ram [64];
    logic [33:0] rdata_q;
    initial begin
        rdata_q <= '0;
        for (int i = 0; i < 64; i++) ram[i] <= {$urandom, 2'($urandom_range(0, 3))};
    end
    always @(posedge CLK) begin
        if (tbl_en) begin
            if (tbl_we) ram[tbl_idx] <= tbl_wdata;
            else        rdata_q      <= ram[tbl_idx];
        end
    end
    assign tbl_rdata = rdata_q;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        logic        tk;
    } ent_t;

    ent_t        mq[$];
    logic [33:0] m_tbl [64];
    int          ph, clr, mcnt;
    bit          m_live = 0;
    int          checks = 0, errors = 0;
    int          nwr = 0;
    logic [33:0] last_wd;
    int          last_idx;
    logic        s_ready, s_grant, s_en, s_we, s_busy;
    int          s_idx, s_mcnt;
    logic [33:0] s_wd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [33:0] m_newval(input logic [33:0] old, input ent_t e);
        int c;
        logic [31:0] tgt;
        c = int'(old[1:0]);
        if (e.tk) c = (c < 3) ? c + 1 : 3;
        else      c = (c > 0) ? c - 1 : 0;
        tgt = e.tk ? (e.addr >> 2) : old[33:2];
        return {tgt, 2'(c)};
    endfunction

    task automatic m_clear();
        ph   = P_CLR;
        clr  = 0;
        mcnt = 0;
        mq.delete();
    endtask

    // One clock cycle: compare against the model, then advance the model at the edge.
    task automatic tick();
        logic e_full, e_ready, e_grant, e_en, e_we, e_busy, pushing, nonempty;
        int e_idx;
        logic [33:0] e_wd;
        #1;
        e_full  = (mq.size() == QD);
        e_ready = nRST && !e_full && (ph != P_CLR);
        e_grant = 0; e_en = 0; e_we = 0; e_idx = 0; e_wd = '0;
        e_busy  = (ph == P_CLR);
        case (ph)
            P_CLR:  begin e_en = 1; e_we = 1; e_idx = clr; end
            P_IDLE: if (lookup_req && !e_full) begin
                        e_grant = 1; e_en = 1; e_idx = int'(lookup_pc[7:2]);
                    end
            P_RD:   begin e_en = 1; e_idx = int'(mq[0].pc[7:2]); end
            default: begin
                e_idx = int'(mq[0].pc[7:2]);
                if (!clear_req) begin
                    e_en = 1; e_we = 1; e_wd = m_newval(m_tbl[e_idx], mq[0]);
                end
            end
        endcase
        if (!nRST) begin e_grant = 0; e_en = 0; e_we = 0; end

        s_ready = upd_ready; s_grant = lookup_grant; s_en = tbl_en; s_we = tbl_we;
        s_busy = busy_clear; s_idx = int'(tbl_idx); s_wd = tbl_wdata; s_mcnt = int'(mispredict_cnt);
        if (m_live) begin
            chk("upd_ready", upd_ready, e_ready);
            chk("lookup_grant", lookup_grant, e_grant);
            chk("tbl_en", tbl_en, e_en);
            chk("tbl_we", tbl_we, e_we);
            chk("busy_clear", busy_clear, e_busy);
            chk("mispredict_cnt", mispredict_cnt, 64'(mcnt));
            if (e_en) chk("tbl_idx", tbl_idx, 64'(e_idx));
            if (e_we) chk("tbl_wdata", tbl_wdata, e_wd);
        end
        if (tbl_en && tbl_we && !busy_clear) begin
            nwr++; last_wd = tbl_wdata; last_idx = int'(tbl_idx);
        end

        @(posedge CLK);
        if (!nRST) begin
            m_clear();
            m_live = 1;
        end else begin
            if (e_en && e_we) m_tbl[e_idx] = e_wd;
            if (clear_req) m_clear();
            else begin
                nonempty = (mq.size() > 0);
                pushing  = update_predictor && e_ready && !is_jalr;
                case (ph)
                    P_CLR: begin
                        if (clr == 63) ph = P_IDLE;
                        clr = (clr + 1) % 64;
                    end
                    P_IDLE: if (nonempty && !(lookup_req && !e_full)) ph = P_RD;
                    P_RD:   ph = P_WR;
                    default: begin void'(mq.pop_front()); ph = P_IDLE; end
                endcase
                if (pushing) begin
                    mq.push_back('{pc: pc_to_update, addr: update_addr, tk: branch_result});
                    if (prediction != branch_result && mcnt < 65535) mcnt++;
                end
            end
        end
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] addr,
                        input logic tk, input logic pr, input logic jl);
        update_predictor = 1; pc_to_update = pc; update_addr = addr;
        branch_result = tk; prediction = pr; is_jalr = jl;
        tick();
        update_predictor = 0; is_jalr = 0;
    endtask

    task automatic run_clear(input string tag, input int first);
        int n, nseq;
        n = first; nseq = first;
        tick();
        while (s_busy && n < 200) begin
            if (s_en && s_we && s_wd == 0 && s_idx == (n % 64)) nseq++;
            n++;
            tick();
        end
        chk({tag, "_busy_cycles"}, n, 64);
        chk({tag, "_seq_writes"}, nseq, 64);
        chk({tag, "_ready_after"}, s_ready, 1);
    endtask

    initial begin
        int n0;
        logic g[5];
        logic r4;
        for (int i = 0; i < 64; i++) m_tbl[i] = '0;
        nRST = 0; update_predictor = 0; branch_result = 0; prediction = 0; is_jalr = 0;
        lookup_req = 0; clear_req = 0; pc_to_update = 0; update_addr = 0; lookup_pc = 0;
        m_clear();
        idle(3);
        chk("rst_busy", s_busy, 1);
        chk("rst_en", s_en, 0);
        chk("rst_ready", s_ready, 0);
        chk("rst_mcnt", s_mcnt, 0);

        nRST = 1;
        run_clear("rel", 0);

        push(32'h100, 32'h200, 1, 1, 0); idle(6);
        chk("tk1_wdata", last_wd, 34'h201);
        push(32'h100, 32'h200, 1, 1, 0); idle(6);
        chk("tk2_wdata", last_wd, 34'h202);
        chk("tk2_idx", last_idx, 0);

        push(32'h104, 32'h999, 0, 0, 0); idle(6);
        chk("nt0_wdata", last_wd, 34'h0);
        chk("nt0_idx", last_idx, 1);
        repeat (4) begin push(32'h108, 32'h400, 1, 1, 0); idle(5); end
        chk("sat3_wdata", last_wd, 34'h403);

        n0 = nwr;
        lookup_req = 1; lookup_pc = 32'h3C;
        for (int i = 0; i < 5; i++) begin
            push(32'h200 + 32'(4 * i), $urandom, 1, 1, 0);
            g[i] = s_grant;
            if (i == 4) r4 = s_ready;
        end
        for (int i = 0; i < 4; i++) chk("lk_grant_fill", g[i], 1);
        chk("lk_grant_full", g[4], 0);
        chk("lk_ready_full", r4, 0);
        tick(); chk("lk_grant_rd", s_grant, 0);
        tick(); chk("lk_grant_wr", s_grant, 0); chk("lk_we_wr", s_we, 1);
        tick(); chk("lk_grant_back", s_grant, 1);
        lookup_req = 0;
        idle(12);
        chk("lk_accepted", nwr - n0, 4);

        n0 = nwr;
        push(32'h300, 32'h700, 1, 0, 1); idle(6);
        chk("jalr_nowr", nwr - n0, 0);
        chk("jalr_mcnt", s_mcnt, 0);
        push(32'h300, 32'h500, 0, 1, 0); idle(6);
        chk("mp_mcnt", s_mcnt, 1);
        chk("mp_wr", nwr - n0, 1);

        n0 = nwr;
        push(32'h140, 32'h880, 1, 0, 0);
        push(32'h144, 32'h884, 1, 1, 0);
        clear_req = 1;
        tick();
        chk("clr_rd_en", s_en, 1);
        chk("clr_rd_we", s_we, 0);
        chk("clr_rd_idx", s_idx, 16);
        chk("clr_rd_mcnt", s_mcnt, 2);
        clear_req = 0;
        tick();
        chk("clr_d_busy", s_busy, 1);
        chk("clr_d_idx", s_idx, 0);
        chk("clr_d_wdata", s_wd, 0);
        chk("clr_d_mcnt", s_mcnt, 0);
        run_clear("clr", 1);
        idle(8);
        chk("clr_flushed", nwr - n0, 0);

        for (int c = 0; c < 4000; c++) begin
            int bias;
            bias = ((c / 500) % 3) * 40;
            nRST = ($urandom_range(0, 399) != 0);
            clear_req = ($urandom_range(0, 149) == 0);
            update_predictor = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0)
                pc_to_update = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 63)) << 2);
            else
                pc_to_update = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
            update_addr   = $urandom;
            branch_result = 1'($urandom_range(0, 1));
            prediction    = 1'($urandom_range(0, 1));
            is_jalr       = ($urandom_range(0, 7) == 0);
            lookup_req    = ($urandom_range(0, 99) < bias);
            lookup_pc     = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bpred_update_ctrl.md
BPRED_UPDATE_CTRL -- requirements
Module: bpred_update_ctrl

Interface
REQ-001 SHALL have parameter QDEPTH, default 4, update FIFO depth (power of 2, >=2).
REQ-002 SHALL have parameter IDX_W, default 6, predictor table index width (2^IDX_W entries).
REQ-003 SHALL have port CLK  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port nRST  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port update_predictor  in  1  resolved-branch update valid.
REQ-006 SHALL have port pc_to_update  in  32  PC of resolved branch.
REQ-007 SHALL have port update_addr  in  32  resolved target address.
REQ-008 SHALL have port branch_result  in  1  actual direction, 1 = taken.
REQ-009 SHALL have port prediction  in  1  direction predicted at fetch.
REQ-010 SHALL have port is_jalr  in  1  update is a JALR.
REQ-011 SHALL have port lookup_req  in  1  fetch requests a table read.
REQ-012 SHALL have port lookup_pc  in  32  fetch PC.
REQ-013 SHALL have port clear_req  in  1  request to invalidate whole table.
REQ-014 SHALL have port tbl_rdata  in  34  table read data {target[33:2], ctr[1:0]}, valid one cycle after a read.
REQ-015 SHALL have port upd_ready  out  1  FIFO accepts an update this cycle.
REQ-016 SHALL have port lookup_grant  out  1  lookup owns the table port this cycle.
REQ-017 SHALL have port tbl_en  out  1  table port access enable.
REQ-018 SHALL have port tbl_we  out  1  table write enable (only with tbl_en).
REQ-019 SHALL have port tbl_idx  out  IDX_W  table index.
REQ-020 SHALL have port tbl_wdata  out  34  table write data {target, ctr}.
REQ-021 SHALL have port busy_clear  out  1  table clear sequence in progress.
REQ-022 SHALL have port mispredict_cnt  out  16  count of accepted mispredicted updates.

Function
REQ-023 SHALL index the table with pc[IDX_W+1:2] for both lookups and updates.
REQ-024 SHALL enqueue {pc_to_update, update_addr, branch_result} when update_predictor && upd_ready && !is_jalr; JALR updates SHALL be dropped.
REQ-025 SHALL drive upd_ready = !full && state != CLEAR; a push while upd_ready=0 SHALL be dropped even if a pop occurs that cycle.
REQ-026 SHALL implement FSM states CLEAR, IDLE, UPD_RD, UPD_WR.
REQ-027 CLEAR: tbl_en=1, tbl_we=1, tbl_wdata=0, tbl_idx = clear counter incrementing by 1 per cycle from 0; after index 2^IDX_W-1 SHALL go to IDLE; busy_clear=1 only in CLEAR.
REQ-028 IDLE: if lookup_req && !full, SHALL assert lookup_grant, tbl_en=1, tbl_we=0, tbl_idx from lookup_pc, and stay IDLE.
REQ-029 IDLE: if FIFO non-empty and (!lookup_req || full), SHALL go to UPD_RD; full FIFO gives update priority over lookup.
REQ-030 UPD_RD: tbl_en=1, tbl_we=0, tbl_idx from head pc; next state UPD_WR unconditionally.
REQ-031 UPD_WR: tbl_en=1, tbl_we=1, same index; ctr = tbl_rdata[1:0] +1 saturating at 3 if taken, -1 saturating at 0 if not taken; target = update_addr if taken else tbl_rdata[33:2]; SHALL pop head and return to IDLE.
REQ-032 lookup_grant SHALL be 0 in every state other than IDLE; tbl_en=0 when no access is issued.
REQ-033 mispredict_cnt SHALL increment by 1 per accepted push with prediction != branch_result, saturating at 0xFFFF.
REQ-034 clear_req sampled high in any state SHALL, next cycle, enter CLEAR with counter 0, flush the FIFO, abandon any UPD_RD/UPD_WR without writing, and zero mispredict_cnt; clear_req during CLEAR restarts at index 0.
REQ-035 Pointer arithmetic SHALL wrap modulo QDEPTH; count SHALL be log2(QDEPTH)+1 bits; simultaneous push and pop SHALL keep count unchanged.

Reset
REQ-036 On CLK edge with nRST=0: state=CLEAR, clear counter=0, FIFO empty, mispredict_cnt=0; registered outputs default 0 except busy_clear=1.
REQ-037 Reset asserted mid-UPD_WR or mid-CLEAR SHALL discard work with no further write; the first cycle after release SHALL be CLEAR at index 0.

Verification
REQ-038 Reset release, IDX_W=6 -> 64 consecutive writes idx 0..63 with wdata 0, busy_clear high 64 cycles, then IDLE, upd_ready=1.
REQ-039 Push pc=0x100, taken, addr=0x200, no lookups, table ctr=1 -> UPD_RD idx 0 then UPD_WR idx 0 wdata {0x200>>2, 2'b10}.
REQ-040 Not-taken update on entry ctr=0 -> written ctr=0 and target unchanged; taken update on ctr=3 -> ctr=3.
REQ-041 lookup_req held high, 4 pushes -> lookups granted until full, then lookup_grant=0 for UPD_RD/UPD_WR, 5th push dropped while upd_ready=0.
REQ-042 Push is_jalr=1 -> FIFO count unchanged; push prediction=1, branch_result=0 -> mispredict_cnt +1; 0xFFFF saturates.
REQ-043 clear_req during UPD_RD with 2 queued -> no write at that idx, FIFO empty, CLEAR from idx 0, mispredict_cnt=0.
